// File: rtl/debounce_multi_input.sv
// ---------------------------------------------------------------------------
// debounce_multi_input
//
// Purpose:
//   N-channel debouncer for mechanical buttons/switches. Each channel has an
//   optional polarity inversion, a 2-FF synchroniser and a stability counter.
//   It produces a registered debounced level, one-cycle rise/fall pulses and
//   an optional one-shot long-press pulse.
//
// Ports:
//   i_Clk      in   1       system clock, rising edge
//   i_Rst_L    in   1       asynchronous active-low reset
//   i_Switch   in   NUM_CH  raw asynchronous pin levels
//   o_Switch   out  NUM_CH  debounced level per channel
//   o_Rise     out  NUM_CH  1-cycle pulse when o_Switch[i] goes 0->1
//   o_Fall     out  NUM_CH  1-cycle pulse when o_Switch[i] goes 1->0
//   o_Hold     out  NUM_CH  1-cycle pulse once per press after HOLD_LIMIT
//                           cycles high (tied low when HOLD_LIMIT == 0)
// ---------------------------------------------------------------------------
module debounce_multi_input #(
  parameter int                NUM_CH         = 4,
  parameter int                DEBOUNCE_LIMIT = 250000,
  parameter int                HOLD_LIMIT     = 0,
  parameter logic [NUM_CH-1:0] INVERT_MASK    = {NUM_CH{1'b0}}
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Hold
);

  localparam int            CW       = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  // Last count value before a change is accepted; the accepting sample
  // itself is the DEBOUNCE_LIMIT-th consecutive differing one.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_sw;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;
  logic [CW-1:0]     r_cnt [NUM_CH];

  logic [NUM_CH-1:0] w_diff;
  logic [NUM_CH-1:0] w_at_last;
  logic [NUM_CH-1:0] w_accept;

  // Two-flop synchroniser; polarity is fixed up before the first flop so
  // everything downstream sees active-high levels.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= {NUM_CH{1'b0}};
      r_sync2 <= {NUM_CH{1'b0}};
    end else begin
      r_sync1 <= i_Switch ^ INVERT_MASK;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff   = r_sync2 ^ r_sw;
  assign w_accept = w_diff & w_at_last;

  // Per-channel flag: counter sits on its final pre-accept value.
  always_comb begin
    w_at_last = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_at_last[i] = (r_cnt[i] == CNT_LAST);
    end
  end

  // Stability counters: any sample matching the current level restarts the
  // count, so only an unbroken run of differing samples is accepted.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_diff[i] || w_at_last[i]) begin
          r_cnt[i] <= CNT_ZERO;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced level and edge pulses update on the same edge, so a pulse is
  // visible in exactly the cycle the new level first appears.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sw   <= {NUM_CH{1'b0}};
      r_rise <= {NUM_CH{1'b0}};
      r_fall <= {NUM_CH{1'b0}};
    end else begin
      r_sw   <= r_sw ^ w_accept;
      r_rise <= w_accept & r_sync2;
      r_fall <= w_accept & ~r_sync2;
    end
  end

  assign o_Switch = r_sw;
  assign o_Rise   = r_rise;
  assign o_Fall   = r_fall;

  generate
    if (HOLD_LIMIT > 0) begin : g_hold
      localparam int            HW       = $clog2(HOLD_LIMIT + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
      localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_LIMIT - 1);
      localparam logic [HW-1:0] HCNT_ONE = HW'(1'b1);

      logic [HW-1:0]     r_hcnt [NUM_CH];
      logic [NUM_CH-1:0] r_hold;

      // Hold counters run while the debounced level is high (the level is
      // still low on the rise edge, which clears them) and saturate so the
      // pulse fires only once per press.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          for (int i = 0; i < NUM_CH; i++) begin
            r_hcnt[i] <= {HW{1'b0}};
          end
          r_hold <= {NUM_CH{1'b0}};
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (!r_sw[i]) begin
              r_hcnt[i] <= {HW{1'b0}};
              r_hold[i] <= 1'b0;
            end else if (r_hcnt[i] == HOLD_MAX) begin
              r_hcnt[i] <= r_hcnt[i];
              r_hold[i] <= 1'b0;
            end else begin
              r_hcnt[i] <= r_hcnt[i] + HCNT_ONE;
              r_hold[i] <= (r_hcnt[i] == HOLD_PRE);
            end
          end
        end
      end

      assign o_Hold = r_hold;
    end else begin : g_no_hold
      assign o_Hold = {NUM_CH{1'b0}};
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi_input.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi_input
//
// Self-checking bench for debounce_multi_input with NUM_CH=4,
// DEBOUNCE_LIMIT=8, HOLD_LIMIT=20, INVERT_MASK=4'b1000. A reference model
// works from sample histories: a level change is accepted once the last
// DEBOUNCE_LIMIT synchronised samples all differ from the current level, and
// a hold pulse appears HOLD_LIMIT cycles after a rise if the level stayed
// high for that whole window.
// ---------------------------------------------------------------------------
module tb_debounce_multi_input;

  localparam int         NCH  = 4;
  localparam int         DL   = 8;
  localparam int         HL   = 20;
  localparam logic [3:0] MASK = 4'b1000;
  localparam int         RING = 64;

  logic       i_Clk    = 1'b0;
  logic       i_Rst_L  = 1'b0;
  logic [3:0] i_Switch = 4'b0000;
  logic [3:0] o_Switch;
  logic [3:0] o_Rise;
  logic [3:0] o_Fall;
  logic [3:0] o_Hold;

  int n_vec = 0;
  int n_err = 0;

  debounce_multi_input #(
    .NUM_CH        (NCH),
    .DEBOUNCE_LIMIT(DL),
    .HOLD_LIMIT    (HL),
    .INVERT_MASK   (MASK)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise  (o_Rise),
    .o_Fall  (o_Fall),
    .o_Hold  (o_Hold)
  );

  always #5 i_Clk = ~i_Clk;

  // ---------------- reference model ----------------
  logic [3:0] m_p1, m_p2;
  logic [3:0] m_sw, m_rise, m_fall, m_hold;
  logic [3:0] s_hist [RING];
  logic [3:0] h_sw   [RING];
  logic [3:0] h_rise [RING];
  int         last_evt [NCH];
  int         cyc = 0;

  function automatic void model_clear();
    m_p1 = 4'b0000; m_p2 = 4'b0000;
    m_sw = 4'b0000; m_rise = 4'b0000; m_fall = 4'b0000; m_hold = 4'b0000;
    for (int ch = 0; ch < NCH; ch++) last_evt[ch] = cyc;
    h_sw[cyc % RING]   = 4'b0000;
    h_rise[cyc % RING] = 4'b0000;
  endfunction

  function automatic void model_edge();
    logic [3:0] s;
    bit acc;
    bit hh;
    cyc = cyc + 1;
    if (!i_Rst_L) begin
      model_clear();
    end else begin
      s = m_p2;
      s_hist[cyc % RING] = s;
      m_rise = 4'b0000;
      m_fall = 4'b0000;
      for (int ch = 0; ch < NCH; ch++) begin
        acc = ((cyc - DL) >= last_evt[ch]);
        if (acc) begin
          for (int k = 0; k < DL; k++)
            if (s_hist[(cyc - k) % RING][ch] == m_sw[ch]) acc = 1'b0;
        end
        if (acc) begin
          m_sw[ch] = ~m_sw[ch];
          if (m_sw[ch]) m_rise[ch] = 1'b1;
          else          m_fall[ch] = 1'b1;
          last_evt[ch] = cyc;
        end
      end
      for (int ch = 0; ch < NCH; ch++) begin
        hh = 1'b0;
        if (cyc >= HL) begin
          hh = h_rise[(cyc - HL) % RING][ch];
          for (int k = 1; k <= HL; k++) hh = hh & h_sw[(cyc - k) % RING][ch];
        end
        m_hold[ch] = hh;
      end
      m_p2 = m_p1;
      m_p1 = i_Switch ^ MASK;
      h_sw[cyc % RING]   = m_sw;
      h_rise[cyc % RING] = m_rise;
    end
  endfunction

  // One clock: model follows the edge, outputs become checkable at negedge.
  task automatic tick();
    @(posedge i_Clk);
    model_edge();
    @(negedge i_Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    int nrise;
    i_Rst_L = 1'b0; i_Switch = 4'b0000;
    repeat (3) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL reset_hold cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    i_Rst_L = 1'b1; i_Switch = 4'b0011;
    repeat (12) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL reset_pre cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    i_Switch = 4'b1100;
    repeat (5) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL reset_mid cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    #2 i_Rst_L = 1'b0;
    model_clear();
    #1 n_vec++;
    if ({o_Switch, o_Rise, o_Fall, o_Hold} !== 16'h0000) begin
      n_err++; $display("FAIL reset_async got %b %b %b %b want all 0", o_Switch, o_Rise, o_Fall, o_Hold);
    end
    repeat (3) begin
      i_Switch = 4'($urandom);
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL reset_toggle cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    i_Switch = 4'b0000;
    #2 i_Rst_L = 1'b1;
    first = 0; nrise = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL reset_exit cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (first == 0 && o_Switch === 4'b1000) first = n;
      if (o_Rise[3] === 1'b1) nrise++;
    end
    n_vec++;
    if (first !== 10) begin n_err++; $display("FAIL reset_latency got edge %0d want 10", first); end
    n_vec++;
    if (nrise !== 1) begin n_err++; $display("FAIL reset_rise3 got %0d pulses want 1", nrise); end
  endtask

  task automatic test_clean_press();
    int first;
    int npulse;
    i_Switch = 4'b0001;
    first = 0; npulse = 0;
    for (int n = 1; n <= 30; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL press cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (first == 0 && o_Switch[0] === 1'b1) first = n;
      if (o_Rise[0] === 1'b1) npulse++;
    end
    n_vec++;
    if (first !== 10) begin n_err++; $display("FAIL press_latency got edge %0d want 10", first); end
    n_vec++;
    if (npulse !== 1) begin n_err++; $display("FAIL press_rise got %0d pulses want 1", npulse); end
    i_Switch = 4'b0000;
    first = 0; npulse = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL release cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (first == 0 && o_Fall[0] === 1'b1) first = n;
      if (o_Fall[0] === 1'b1) npulse++;
    end
    n_vec++;
    if (first !== 10 || npulse !== 1) begin
      n_err++; $display("FAIL release_fall got edge %0d count %0d want edge 10 count 1", first, npulse);
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int n = 0; n < 16; n++) begin
      i_Switch = (n == 7 || n == 15) ? 4'b0000 : 4'b0010;
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL glitch cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (o_Switch[1] !== 1'b0 || o_Rise[1] !== 1'b0 || o_Fall[1] !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL glitch_reject got %0d active cycles want 0", seen); end
    i_Switch = 4'b0010;
    repeat (14) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL glitch_accept cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    n_vec++;
    if (o_Switch[1] !== 1'b1) begin n_err++; $display("FAIL glitch_final got %b want 1", o_Switch[1]); end
    i_Switch = 4'b0000;
    repeat (14) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL glitch_off cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_long_press();
    int found;
    int first;
    int nhold;
    for (int pass = 0; pass < 2; pass++) begin
      i_Switch = 4'b0100;
      found = 0;
      for (int n = 1; n <= 20 && found == 0; n++) begin
        tick(); n_vec++;
        if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
          n_err++; $display("FAIL long_wait cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
        end
        if (o_Rise[2] === 1'b1) found = 1;
      end
      n_vec++;
      if (found !== 1) begin n_err++; $display("FAIL long_rise got no o_Rise[2] want pulse"); end
      first = 0; nhold = 0;
      for (int k = 1; k <= 40; k++) begin
        if (pass == 1 && k == 5) i_Switch = 4'b0000;
        tick(); n_vec++;
        if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
          n_err++; $display("FAIL long_run cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
        end
        if (o_Hold[2] === 1'b1) begin nhold++; if (first == 0) first = k; end
      end
      n_vec++;
      if (pass == 0 && (first !== 20 || nhold !== 1)) begin
        n_err++; $display("FAIL long_hold got at %0d count %0d want at 20 count 1", first, nhold);
      end else if (pass == 1 && nhold !== 0) begin
        n_err++; $display("FAIL short_hold got count %0d want 0", nhold);
      end
      i_Switch = 4'b0000;
      repeat (14) begin
        tick(); n_vec++;
        if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
          n_err++; $display("FAIL long_off cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] first_rise;
    logic       ch1_seen;
    first_rise = 4'b0000; ch1_seen = 1'b0;
    i_Switch = 4'b0101;
    for (int n = 1; n <= 40; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL simul cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (first_rise == 4'b0000 && o_Rise !== 4'b0000) first_rise = o_Rise;
      if (o_Switch[1] !== 1'b0) ch1_seen = 1'b1;
    end
    n_vec++;
    if (first_rise !== 4'b0101) begin n_err++; $display("FAIL simul_rise got %b want 0101", first_rise); end
    n_vec++;
    if (ch1_seen !== 1'b0) begin n_err++; $display("FAIL simul_ch1 got activity want none"); end
    i_Switch = 4'b0000;
    repeat (14) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL simul_off cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_reset_during_hold();
    int found;
    int first;
    int nhold;
    nhold = 0;
    i_Switch = 4'b0100;
    found = 0;
    for (int n = 1; n <= 20 && found == 0; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL rdh_wait cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (o_Rise[2] === 1'b1) found = 1;
    end
    repeat (10) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL rdh_held cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (o_Hold[2] === 1'b1) nhold++;
    end
    #2 i_Rst_L = 1'b0;
    model_clear();
    #1 n_vec++;
    if ({o_Switch, o_Rise, o_Fall, o_Hold} !== 16'h0000) begin
      n_err++; $display("FAIL rdh_clear got %b %b %b %b want all 0", o_Switch, o_Rise, o_Fall, o_Hold);
    end
    repeat (2) tick();
    #2 i_Rst_L = 1'b1;
    found = 0;
    for (int n = 1; n <= 20 && found == 0; n++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL rdh_rewait cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (o_Hold[2] === 1'b1) nhold++;
      if (o_Rise[2] === 1'b1) found = 1;
    end
    n_vec++;
    if (found !== 1) begin n_err++; $display("FAIL rdh_rise got no o_Rise[2] want pulse"); end
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL rdh_run cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
      if (o_Hold[2] === 1'b1) begin nhold++; if (first == 0) first = k; end
    end
    n_vec++;
    if (first !== 20 || nhold !== 1) begin
      n_err++; $display("FAIL rdh_hold got at %0d count %0d want at 20 count 1", first, nhold);
    end
    i_Switch = 4'b0000;
    repeat (14) tick();
  endtask

  task automatic test_random();
    int run [NCH];
    for (int ch = 0; ch < NCH; ch++) run[ch] = 1;
    for (int n = 0; n < 2000; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        run[ch]--;
        if (run[ch] <= 0) begin
          i_Switch[ch] = ~i_Switch[ch];
          run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 12));
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        i_Rst_L = 1'b0;
        model_clear();
      end else begin
        i_Rst_L = 1'b1;
      end
      tick(); n_vec++;
      if ({o_Switch, o_Rise, o_Fall, o_Hold} !== {m_sw, m_rise, m_fall, m_hold}) begin
        n_err++; $display("FAIL random cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, o_Switch, o_Rise, o_Fall, o_Hold, m_sw, m_rise, m_fall, m_hold);
      end
    end
    i_Rst_L = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < RING; r++) begin
      s_hist[r] = 4'b0000; h_sw[r] = 4'b0000; h_rise[r] = 4'b0000;
    end
    model_clear();
    @(negedge i_Clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_during_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
